// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for elastic pipeline stages
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  wb_sel;
      logic [2:0]  funct3;
   } ex_mem_t;

   localparam int EX_MEM_W = $bits(ex_mem_t);

   // reg_write/mem_read/mem_write sit just above wb_sel and funct3
   localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE_MASK = EX_MEM_W'(8'hE0);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - valid/ready pipeline stage with optional skid entry, flush and stall stats
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                   PAYLOAD_W   = EX_MEM_W,
   parameter logic [PAYLOAD_W-1:0] BUBBLE_MASK = '0,
   parameter bit                   SKID        = 1'b1,
   parameter int                   CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           occupancy,
   input  logic                 clr_stats,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam logic [PAYLOAD_W-1:0] KEEP_MASK = ~BUBBLE_MASK;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   generate
      if (SKID) begin : g_skid
         skid_state_e          state;
         logic [PAYLOAD_W-1:0] main_q;
         logic [PAYLOAD_W-1:0] skid_q;
         logic                 in_ready_q;

         // in_ready_q tracks "next state is not TWO" so it never sees out_ready combinationally
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state      <= EMPTY;
               main_q     <= '0;
               skid_q     <= '0;
               in_ready_q <= 1'b1;
            end else if (flush) begin
               state      <= EMPTY;
               main_q     <= main_q & KEEP_MASK;
               skid_q     <= skid_q & KEEP_MASK;
               in_ready_q <= 1'b1;
            end else begin
               case (state)
                  EMPTY: begin
                     if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_data;
                     end
                  end
                  ONE: begin
                     if (in_fire && out_fire) begin
                        main_q <= in_data;
                     end else if (in_fire) begin
                        state      <= TWO;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                     end else if (out_fire) begin
                        state <= EMPTY;
                     end
                  end
                  TWO: begin
                     if (out_fire) begin
                        state      <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                     end
                  end
                  default: begin
                     state      <= EMPTY;
                     in_ready_q <= 1'b1;
                  end
               endcase
            end
         end

         assign in_ready  = in_ready_q;
         assign out_valid = (state != EMPTY);
         assign out_data  = main_q;
         assign occupancy = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
      end else begin : g_single
         logic                 valid_q;
         logic [PAYLOAD_W-1:0] data_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else if (flush) begin
               valid_q <= 1'b0;
               data_q  <= data_q & KEEP_MASK;
            end else if (in_fire) begin
               valid_q <= 1'b1;
               data_q  <= in_data;
            end else if (out_fire) begin
               valid_q <= 1'b0;
            end
         end

         assign in_ready  = !valid_q || out_ready;
         assign out_valid = valid_q;
         assign out_data  = data_q;
         assign occupancy = {1'b0, valid_q};
      end
   endgenerate

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (out_valid && !out_ready),
      .clr  (clr_stats),
      .count(stall_cycles)
   );

endmodule
